// File: rtl/ifmap_window_gen_if.sv
// Stream bundle for ifmap_window_gen: raster pixel input and 3x3 window output.
interface ifmap_window_gen_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
);
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  // Pixel input
  logic                   pix_valid;
  logic                   pix_ready;
  logic [DATA_W-1:0]      pix_data;

  // Window output
  logic                   win_valid;
  logic                   win_ready;
  logic [8:0][DATA_W-1:0] ifmap_3x3;
  logic [RowW-1:0]        win_row;
  logic [ColW-1:0]        win_col;
  logic                   win_last;

  // Producer of pixels / consumer of windows
  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, ifmap_3x3, win_row, win_col, win_last
  );

  // The window generator itself
  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, ifmap_3x3, win_row, win_col, win_last
  );
endinterface

// File: rtl/ifmap_window_gen.sv
// Streaming 3x3 window generator (no padding, stride 1) built from two line
// buffers and a 3x3 column shift register. Pixel words are opaque.
module ifmap_window_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input logic               clk,
  input logic               rst,
  ifmap_window_gen_if.slave bus_io
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowTwo  = RowW'(2);

  // Input position counters
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Line buffers: lb0 holds the previous row, lb1 the row before that
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // Window shift register doubles as the output register
  logic [8:0][DATA_W-1:0] win_q, win_d;
  logic                   win_valid_q, win_valid_d;
  logic                   win_last_q, win_last_d;
  logic [RowW-1:0]        win_row_q, win_row_d;
  logic [ColW-1:0]        win_col_q, win_col_d;

  logic pix_ready;
  logic accept;
  logic xfer;
  logic col_end;
  logic row_end;
  logic emit;

  // A held window blocks input so the shift register cannot disturb it
  assign pix_ready = !win_valid_q || bus_io.win_ready;
  assign accept    = bus_io.pix_valid && pix_ready;
  assign xfer      = win_valid_q && bus_io.win_ready;
  assign col_end   = (col_q == ColLast);
  assign row_end   = (row_q == RowLast);
  // Rows 0-1 and cols 0-1 only prime the buffers; this also hides stale
  // line buffer contents left over from the previous frame.
  assign emit      = accept && (row_q >= RowTwo) && (col_q >= ColTwo);

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];

  // Next raster position, wrapping at end of row and end of frame
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Shift the window left and insert the new right-hand column
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = bus_io.pix_data;
    end
  end

  // Output valid and window position tags
  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - RowTwo;
      win_col_d   = col_q - ColTwo;
      win_last_d  = row_end && col_end;
    end else if (xfer) begin
      win_valid_d = 1'b0;
    end
  end

  // Line buffer RAM: read-before-write, contents never reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus_io.pix_data;
    end
  end

  // Control and window state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign bus_io.pix_ready = pix_ready;
  assign bus_io.win_valid = win_valid_q;
  assign bus_io.ifmap_3x3 = win_q;
  assign bus_io.win_row   = win_row_q;
  assign bus_io.win_col   = win_col_q;
  assign bus_io.win_last  = win_last_q;

endmodule
